// File: rtl/i2c_slave_pkg.sv
// Shared constants for the I2C register target: FSM state codes, default device
// address and bit-counter width.
package i2c_slave_pkg;

  localparam logic [7:0] DEV_ID_DEFAULT = 8'h34;
  localparam int unsigned BitCntW = 4;

  typedef logic [3:0] i2c_state_t;

  localparam i2c_state_t StIdle      = 4'd0;
  localparam i2c_state_t StDev       = 4'd1;
  localparam i2c_state_t StDevAck    = 4'd2;
  localparam i2c_state_t StReg       = 4'd3;
  localparam i2c_state_t StRegAck    = 4'd4;
  localparam i2c_state_t StWData     = 4'd5;
  localparam i2c_state_t StWDataAck  = 4'd6;
  localparam i2c_state_t StRData     = 4'd7;
  localparam i2c_state_t StRDataAck  = 4'd8;
  localparam i2c_state_t StWaitStop  = 4'd9;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into the system clock and derives SCL edges plus
// START/STOP conditions from the synchronized levels.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign sda_o      = sda_sync_q[1];
  assign scl_rise_o = scl_sync_q[1] & ~scl_hist_q;
  assign scl_fall_o = ~scl_sync_q[1] & scl_hist_q;
  assign start_o    = scl_sync_q[1] & scl_hist_q & sda_hist_q & ~sda_sync_q[1];
  assign stop_o     = scl_sync_q[1] & scl_hist_q & ~sda_hist_q & sda_sync_q[1];

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C register target: device match, register pointer with auto-increment and
// write strobes. Define I2C_SLAVE_READ_EN to add the read (RDATA) path.
module i2c_slave_regs
  import i2c_slave_pkg::*;
#(
  parameter logic [7:0] DEV_ID = DEV_ID_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i2c_sclk,
  input  logic       i2c_sdat_i,
  output logic       i2c_sdat_oe,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [BitCntW-1:0] CntOne  = BitCntW'(1);
  localparam logic [BitCntW-1:0] CntByte = BitCntW'(8);
  localparam logic [BitCntW-1:0] CntAck  = BitCntW'(9);

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_bus_sync u_sync (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .scl_i      (i2c_sclk),
    .sda_i      (i2c_sdat_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  i2c_state_t         state_q, state_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               oe_q, oe_d;
  logic               wr_q, wr_d;
  logic               busy_q, busy_d;

`ifndef I2C_SLAVE_READ_EN
  logic unused_rdata;
  assign unused_rdata = ^reg_rdata;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    oe_d      = oe_q;
    wr_d      = 1'b0;
    busy_d    = busy_q;
    if (stop) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else if (start) begin
      state_d   = StDev;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        StDev, StReg, StWData: begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + CntOne;
          if (state_q == StWData && bit_cnt_q == CntByte - CntOne) begin
            wdata_d = {shift_q[6:0], sda_s};
            wr_d    = 1'b1;
          end
        end
        StDevAck, StRegAck, StWDataAck: bit_cnt_d = bit_cnt_q + CntOne;
`ifdef I2C_SLAVE_READ_EN
        StRData: bit_cnt_d = bit_cnt_q + CntOne;
        StRDataAck: begin
          bit_cnt_d = bit_cnt_q + CntOne;
          // Master ACK advances the pointer now so reg_rdata settles before the reload.
          if (sda_s) state_d = StWaitStop;
          else       addr_d  = addr_q + 8'd1;
        end
`endif
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        StDev: if (bit_cnt_q == CntByte) begin
          if (shift_q[7:1] != DEV_ID[7:1]) begin
            state_d = StWaitStop;
            busy_d  = 1'b0;
          end
`ifndef I2C_SLAVE_READ_EN
          else if (shift_q[0]) begin
            state_d = StWaitStop;
            busy_d  = 1'b0;
          end
`endif
          else begin
            state_d = StDevAck;
            oe_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
        StDevAck: if (bit_cnt_q == CntAck) begin
          state_d   = StReg;
          bit_cnt_d = '0;
          oe_d      = 1'b0;
`ifdef I2C_SLAVE_READ_EN
          if (shift_q[0]) begin
            state_d = StRData;
            shift_d = reg_rdata;
            oe_d    = ~reg_rdata[7];
          end
`endif
        end
        StReg: if (bit_cnt_q == CntByte) begin
          state_d = StRegAck;
          addr_d  = shift_q;
          oe_d    = 1'b1;
        end
        StRegAck, StWDataAck: if (bit_cnt_q == CntAck) begin
          state_d   = StWData;
          bit_cnt_d = '0;
          oe_d      = 1'b0;
          if (state_q == StWDataAck) addr_d = addr_q + 8'd1;
        end
        StWData: if (bit_cnt_q == CntByte) begin
          state_d = StWDataAck;
          oe_d    = 1'b1;
        end
`ifdef I2C_SLAVE_READ_EN
        StRData: begin
          if (bit_cnt_q == CntByte) begin
            state_d = StRDataAck;
            oe_d    = 1'b0;
          end else if (bit_cnt_q != '0) begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
          end
        end
        StRDataAck: if (bit_cnt_q == CntAck) begin
          state_d   = StRData;
          bit_cnt_d = '0;
          shift_d   = reg_rdata;
          oe_d      = ~reg_rdata[7];
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      oe_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      oe_q      <= oe_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
    end
  end

  assign i2c_sdat_oe = oe_q;
  assign reg_wr      = wr_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bus-level master tasks, write scoreboard and direct
// checks of ACKs and read bytes; follows I2C_SLAVE_READ_EN if defined.
module tb_i2c_slave_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       oe, reg_wr, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  wire        sda_bus = sda_m & ~oe;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [15:0] exp_wr_q[$];
  logic        oe_seen = 1'b0;
  logic        wr_prev = 1'b0;

  assign reg_rdata = reg_addr ^ 8'h5A;

  i2c_slave_regs dut (
    .Clk         (clk),
    .Rst         (rst),
    .i2c_sclk    (scl),
    .i2c_sdat_i  (sda_bus),
    .i2c_sdat_oe (oe),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Scoreboard side: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && oe) oe_seen = 1'b1;
    if (!rst && reg_wr) begin
      check_eq("wr_width", {31'd0, wr_prev}, 32'd0);
      check_eq("wr_expected", {31'd0, exp_wr_q.size() != 0}, 32'd1);
      if (exp_wr_q.size() != 0) check_eq("wr_data", {16'd0, reg_addr, reg_wdata},
                                         {16'd0, exp_wr_q.pop_front()});
    end
    wr_prev = reg_wr;
  end

  task automatic quarter();
    repeat (8) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; quarter();
    scl = 1'b1;   quarter();
    sda_m = 1'b0; quarter();
    scl = 1'b0;   quarter();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; quarter();
    scl = 1'b1;   quarter();
    sda_m = 1'b1; quarter();
  endtask

  task automatic bit_cycle(input logic b, output logic sampled);
    sda_m = b;  quarter();
    scl = 1'b1; quarter();
    sampled = sda_bus;
    quarter();
    scl = 1'b0; quarter();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(master_ack, s);
  endtask

  task automatic wr_txn(input logic [7:0] dev, input logic [7:0] ra, input logic [7:0] d0);
    logic ack;
    i2c_start();
    write_byte(dev, ack); check_eq("dev_ack", {31'd0, ack}, 32'd0);
    write_byte(ra, ack);  check_eq("reg_ack", {31'd0, ack}, 32'd0);
    exp_wr_q.push_back({ra, d0});
    write_byte(d0, ack);  check_eq("data_ack", {31'd0, ack}, 32'd0);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_oe", {31'd0, oe}, 32'd0);
    check_eq("rst_wr", {31'd0, reg_wr}, 32'd0);
    check_eq("rst_addr", {24'd0, reg_addr}, 32'd0);
    check_eq("rst_wdata", {24'd0, reg_wdata}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    quarter();

    // Single write
    wr_txn(8'h34, 8'h07, 8'h0A);
    check_eq("busy_active", {31'd0, busy}, 32'd1);
    i2c_stop(); quarter();
    check_eq("busy_after_stop", {31'd0, busy}, 32'd0);

    // Burst across the 0xFF -> 0x00 wrap
    wr_txn(8'h34, 8'hFF, 8'h11);
    exp_wr_q.push_back({8'h00, 8'h22});
    write_byte(8'h22, ack); check_eq("burst_ack", {31'd0, ack}, 32'd0);
    i2c_stop(); quarter();
    check_eq("burst_addr", {24'd0, reg_addr}, 32'h01);

    // Address mismatch, then a valid write
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h36, ack); check_eq("mis_nack", {31'd0, ack}, 32'd1);
    check_eq("mis_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h07, ack); check_eq("mis_reg_nack", {31'd0, ack}, 32'd1);
    i2c_stop(); quarter();
    check_eq("mis_no_oe", {31'd0, oe_seen}, 32'd0);
    wr_txn(8'h34, 8'h20, 8'h55);
    i2c_stop(); quarter();

    // Read via repeated START (0x35 matches too)
    i2c_start();
    write_byte(8'h34, ack); check_eq("rd_dev_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h10, ack); check_eq("rd_reg_ack", {31'd0, ack}, 32'd0);
    i2c_start();
    write_byte(8'h35, ack);
`ifdef I2C_SLAVE_READ_EN
    check_eq("rd_addr_ack", {31'd0, ack}, 32'd0);
    read_byte(1'b0, d); check_eq("rd_byte0", {24'd0, d}, 32'h4A);
    read_byte(1'b1, d); check_eq("rd_byte1", {24'd0, d}, 32'h4B);
`else
    check_eq("rd_addr_nack", {31'd0, ack}, 32'd1);
`endif
    oe_seen = 1'b0;
    read_byte(1'b1, d);
    check_eq("rd_idle_bus", {24'd0, d}, 32'hFF);
    check_eq("rd_no_drive", {31'd0, oe_seen}, 32'd0);
    i2c_stop(); quarter();

    // STOP after 4 data bits: no strobe, no increment
    i2c_start();
    write_byte(8'h34, ack); check_eq("ab_dev_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h30, ack); check_eq("ab_reg_ack", {31'd0, ack}, 32'd0);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, s);
    i2c_stop(); quarter();
    check_eq("ab_addr", {24'd0, reg_addr}, 32'h30);
    check_eq("ab_busy", {31'd0, busy}, 32'd0);

    // Reset while the DUT holds an ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_cycle(d[i] & 1'b0 | (8'h34 >> i) & 1'b1, s);
    sda_m = 1'b1; quarter();
    scl = 1'b1;   quarter();
    check_eq("ack_held", {31'd0, oe}, 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    check_eq("rst_mid_ack_oe", {31'd0, oe}, 32'd0);
    check_eq("rst_mid_ack_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    quarter();
    scl = 1'b0; quarter();
    i2c_stop(); quarter();

    check_eq("wr_drained", exp_wr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
